// File: rtl/alu_ctl_seq.sv
// ALU control decoder with a registered control code and an iterative WIDTH-bit
// multiply/divide sequencer owning HI/LO. Define SIGNED_MD_EN for two's-complement mult/div.
module alu_ctl_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic [3:0]       alu_ctl_o,
    output logic             illegal_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [3:0]       alu_ctl_q, alu_ctl_d;
    logic             illegal_q, illegal_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;

    logic [3:0]       dec_ctl;
    logic             dec_ill, dec_mult, dec_div, accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [ACC_W-1:0] mul_next, div_next, mul_res;
    logic [WIDTH-1:0] div_quo, div_rem;

    // Funct/ALUOp decode; illegal only tracks R-type accepts
    always_comb begin
        dec_ctl  = 4'b0010;
        dec_ill  = illegal_q;
        dec_mult = 1'b0;
        dec_div  = 1'b0;
        case (op_i)
            3'b001:  dec_ctl = 4'b0110;
            3'b011:  dec_ctl = 4'b0000;
            3'b100:  dec_ctl = 4'b0001;
            3'b101:  dec_ctl = 4'b0111;
            3'b010: begin
                dec_ill = 1'b0;
                case (funct_i)
                    6'b100000: dec_ctl = 4'b0010;
                    6'b100010: dec_ctl = 4'b0110;
                    6'b100100: dec_ctl = 4'b0000;
                    6'b100101: dec_ctl = 4'b0001;
                    6'b101010: dec_ctl = 4'b0111;
                    6'b100110: dec_ctl = 4'b0101;
                    6'b100111: dec_ctl = 4'b1100;
                    6'b011000: begin dec_ctl = 4'b1000; dec_mult = 1'b1; end
                    6'b011010: begin dec_ctl = 4'b1010; dec_div  = 1'b1; end
                    6'b010000: dec_ctl = 4'b1101;
                    6'b010010: dec_ctl = 4'b1110;
                    default: begin dec_ctl = 4'b1111; dec_ill = 1'b1; end
                endcase
            end
            default: dec_ctl = 4'b0010;
        endcase
    end

    assign accept = valid_i && ready_q;

`ifdef SIGNED_MD_EN
    logic neg_q, neg_d, rneg_q, rneg_d;
    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;
`else
    assign a_mag = a_i;
    assign b_mag = b_i;
`endif

    // One iteration step: acc holds {partial/remainder, multiplier/quotient}
    assign mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

`ifdef SIGNED_MD_EN
    assign mul_res = neg_q  ? -mul_next : mul_next;
    assign div_quo = neg_q  ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign div_rem = rneg_q ? -div_next[ACC_W-1:WIDTH] : div_next[ACC_W-1:WIDTH];
`else
    assign mul_res = mul_next;
    assign div_quo = div_next[WIDTH-1:0];
    assign div_rem = div_next[ACC_W-1:WIDTH];
`endif

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        alu_ctl_d = alu_ctl_q;
        illegal_d = illegal_q;
`ifdef SIGNED_MD_EN
        neg_d     = neg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    alu_ctl_d = dec_ctl;
                    illegal_d = dec_ill;
`ifdef SIGNED_MD_EN
                    neg_d     = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    rneg_d    = a_i[WIDTH-1];
`endif
                    if (dec_mult) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                    end else if (dec_div && (b_i == '0)) begin
                        state_d = S_DONE;
                        hi_d    = a_i;
                        lo_d    = '1;
                    end else if (dec_div) begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    {hi_d, lo_d} = mul_res;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d  = (state_d == S_MUL)  || (state_d == S_DIV);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            alu_ctl_q <= 4'b0010;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIGNED_MD_EN
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            alu_ctl_q <= alu_ctl_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SIGNED_MD_EN
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign alu_ctl_o = alu_ctl_q;
    assign illegal_o = illegal_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule
